// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the instruction-fetch stage.
// Contents: reset PC default, instruction word width, 2-bit branch
// counter encodings and saturating counter helpers.
package if_fetch_unit_pkg;

    localparam int unsigned INSTR_W          = 32;
    localparam logic [31:0] DEFAULT_PC_RESET = 32'h0000_0000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    function automatic cnt_e cnt_inc(input cnt_e c);
        case (c)
            SNT:     return WNT;
            WNT:     return WT;
            default: return ST;
        endcase
    endfunction

    function automatic cnt_e cnt_dec(input cnt_e c);
        case (c)
            ST:      return WT;
            WT:      return WNT;
            default: return SNT;
        endcase
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// Bus bundle between the fetch unit and the rest of the pipeline.
// master: pipeline/memory side (drives run/stall, redirect, BTB update,
//         instruction data; receives fetch address, PC, instruction, prediction).
// slave:  the fetch unit itself.
interface if_fetch_unit_if;
    import if_fetch_unit_pkg::*;

    logic               run;
    logic               stall;
    logic               redirect_valid;
    logic [31:0]        redirect_pc;
    logic               upd_valid;
    logic [31:0]        upd_pc;
    logic               upd_taken;
    logic [31:0]        upd_target;
    logic [31:0]        imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [31:0]        if_pc;
    logic [INSTR_W-1:0] if_instr;
    logic               if_pred_taken;

    modport master (
        output run, stall, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target, imem_data,
        input  imem_addr, if_pc, if_instr, if_pred_taken
    );

    modport slave (
        input  run, stall, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target, imem_data,
        output imem_addr, if_pc, if_instr, if_pred_taken
    );

endinterface

// File: rtl/if_fetch_unit_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   lk_pc                       lookup address (combinational read)
//   lk_pred_taken, lk_target    hit && counter MSB, stored target
//   upd_valid/pc/taken/target   resolved-branch update, written on the clock edge
module btb_2bit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] lk_pc,
    output logic        lk_pred_taken,
    output logic [31:0] lk_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target
);

    localparam int unsigned ENTRIES = 1 << IDX_W;
    localparam int unsigned TAG_W   = 30 - IDX_W;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    cnt_e               cnt_q    [ENTRIES];
    cnt_e               cnt_d    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit;

    // Low address bits never take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

    assign lk_idx  = lk_pc[IDX_W+1:2];
    assign lk_tag  = lk_pc[31:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[31:IDX_W+2];

    // Lookup reads the registered state, so a same-cycle update is seen next cycle.
    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_pred_taken = lk_hit && cnt_q[lk_idx][1];
    assign lk_target     = target_q[lk_idx];
    assign upd_hit       = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (upd_valid) begin
            if (upd_taken) begin
                target_d[upd_idx] = upd_target;
                if (upd_hit) begin
                    cnt_d[upd_idx] = cnt_inc(cnt_q[upd_idx]);
                end else begin
                    // Taken miss evicts whatever occupied the slot.
                    valid_d[upd_idx] = 1'b1;
                    tag_d[upd_idx]   = upd_tag;
                    cnt_d[upd_idx]   = WT;
                end
            end else if (upd_hit) begin
                cnt_d[upd_idx] = cnt_dec(cnt_q[upd_idx]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= WNT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage feeding the IF/ID register.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   bus          if_fetch_unit_if.slave: run/stall, EX redirect, BTB update,
//                imem address/data, IF/ID outputs (pc, instr, prediction)
// Holds the PC register and next-PC selection; prediction comes from btb_2bit.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned BTB_IDX_W = 4,
    parameter logic [31:0] PC_RESET  = DEFAULT_PC_RESET
) (
    input  logic          clk,
    input  logic          rst_n,
    if_fetch_unit_if.slave bus
);

    logic [31:0] pc_q, pc_d;
    logic        pred_taken;
    logic [31:0] pred_target;

    btb_2bit #(
        .IDX_W(BTB_IDX_W)
    ) u_btb (
        .clk           (clk),
        .rst_n         (rst_n),
        .lk_pc         (pc_q),
        .lk_pred_taken (pred_taken),
        .lk_target     (pred_target),
        .upd_valid     (bus.upd_valid),
        .upd_pc        (bus.upd_pc),
        .upd_taken     (bus.upd_taken),
        .upd_target    (bus.upd_target)
    );

    // Redirect beats run/stall; a frozen or stalled stage otherwise holds.
    always_comb begin
        pc_d = pc_q;
        if (bus.redirect_valid) begin
            pc_d = bus.redirect_pc;
        end else if (!bus.run || bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.imem_addr     = pc_q;
    assign bus.if_pc         = pc_q;
    assign bus.if_instr      = bus.imem_data;
    assign bus.if_pred_taken = pred_taken;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    typedef struct packed {
        logic        run;
        logic        stall;
        logic        rv;
        logic [31:0] rpc;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utg;
        logic [31:0] exp_pc;
        logic        exp_pred;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    vec_t vq[$];

    if_fetch_unit_if bus();

    if_fetch_unit #(
        .BTB_IDX_W (4),
        .PC_RESET  (32'h0000_0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Instruction memory model: word is a fixed function of its address.
    assign bus.imem_data = bus.imem_addr ^ 32'hDEAD_BEEF;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input logic run, input logic stall, input logic rv,
                               input logic [31:0] rpc, input logic uv,
                               input logic [31:0] upc, input logic ut,
                               input logic [31:0] utg, input logic [31:0] epc,
                               input logic epred);
        vec_t r;
        r.run = run; r.stall = stall; r.rv = rv; r.rpc = rpc; r.uv = uv;
        r.upc = upc; r.ut = ut; r.utg = utg; r.exp_pc = epc; r.exp_pred = epred;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] epc, input logic epred);
        check({tag, "_pc"},    bus.if_pc, epc);
        check({tag, "_addr"},  bus.imem_addr, epc);
        check({tag, "_instr"}, bus.if_instr, epc ^ 32'hDEAD_BEEF);
        check({tag, "_pred"},  {31'b0, bus.if_pred_taken}, {31'b0, epred});
    endtask

    task automatic drive(input vec_t x);
        bus.run = x.run; bus.stall = x.stall;
        bus.redirect_valid = x.rv; bus.redirect_pc = x.rpc;
        bus.upd_valid = x.uv; bus.upd_pc = x.upc;
        bus.upd_taken = x.ut; bus.upd_target = x.utg;
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //       run stall rv rpc            uv upc         ut utg          exp_pc        pred
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0000, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0004, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0008, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_000C, L));
        vq.push_back(v(H, H, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0010, L));
        vq.push_back(v(H, H, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0010, L));
        vq.push_back(v(H, H, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0010, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0010, L));
        vq.push_back(v(L, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0014, L));
        vq.push_back(v(H, H, H, 32'h200,      L, 32'h0,   L, 32'h0,   32'h0000_0014, L));
        vq.push_back(v(L, L, H, 32'h3C,       L, 32'h0,   L, 32'h0,   32'h0000_0200, L));
        vq.push_back(v(H, L, L, 32'h0,        H, 32'h40,  H, 32'h100, 32'h0000_003C, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0040, H));
        vq.push_back(v(H, L, L, 32'h0,        H, 32'h40,  L, 32'h0,   32'h0000_0100, L));
        vq.push_back(v(H, L, L, 32'h0,        H, 32'h40,  L, 32'h0,   32'h0000_0104, L));
        vq.push_back(v(H, L, H, 32'h40,       L, 32'h0,   L, 32'h0,   32'h0000_0108, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0040, L));
        for (int i = 0; i < 5; i++)
            vq.push_back(v(L, L, L, 32'h0,    H, 32'h40,  H, 32'h100, 32'h0000_0044, L));
        vq.push_back(v(L, L, L, 32'h0,        H, 32'h40,  L, 32'h0,   32'h0000_0044, L));
        vq.push_back(v(H, L, H, 32'h40,       L, 32'h0,   L, 32'h0,   32'h0000_0044, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0040, H));
        vq.push_back(v(L, L, L, 32'h0,        H, 32'h440, H, 32'h300, 32'h0000_0100, L));
        vq.push_back(v(H, L, H, 32'h40,       L, 32'h0,   L, 32'h0,   32'h0000_0100, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0040, L));
        vq.push_back(v(H, L, H, 32'h440,      L, 32'h0,   L, 32'h0,   32'h0000_0044, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0440, H));
        vq.push_back(v(H, L, H, 32'h48,       L, 32'h0,   L, 32'h0,   32'h0000_0300, L));
        vq.push_back(v(L, L, L, 32'h0,        H, 32'h48,  H, 32'h500, 32'h0000_0048, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0048, H));
        vq.push_back(v(H, L, H, 32'hFFFF_FFFC, L, 32'h0,  L, 32'h0,   32'h0000_0500, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'hFFFF_FFFC, L));
        vq.push_back(v(H, L, H, 32'h203,      L, 32'h0,   L, 32'h0,   32'h0000_0000, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0203, L));
        vq.push_back(v(H, L, L, 32'h0,        L, 32'h0,   L, 32'h0,   32'h0000_0207, L));

        // Reset state
        rst_n = 1'b0;
        drive(v(L, L, L, 32'h0, L, 32'h0, L, 32'h0, 32'h0, L));
        repeat (2) @(negedge clk);
        #1 check_outputs("reset", 32'h0, L);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i]);
            #1 check_outputs($sformatf("v%0d", i), vq[i].exp_pc, vq[i].exp_pred);
        end

        // Asynchronous reset mid-cycle clears PC and the trained 0x48 entry.
        @(negedge clk);
        drive(v(H, L, H, 32'h48, L, 32'h0, L, 32'h0, 32'h0, L));
        @(negedge clk);
        drive(v(L, L, L, 32'h0, L, 32'h0, L, 32'h0, 32'h0, L));
        #1 check_outputs("pre_rst", 32'h48, H);
        #2 rst_n = 1'b0;
        #1 check_outputs("async_rst", 32'h0, L);
        @(negedge clk);
        rst_n = 1'b1;
        drive(v(L, L, H, 32'h48, L, 32'h0, L, 32'h0, 32'h0, L));
        @(negedge clk);
        drive(v(L, L, H, 32'h440, L, 32'h0, L, 32'h0, 32'h0, L));
        #1 check_outputs("post_rst_48", 32'h48, L);
        @(negedge clk);
        drive(v(H, L, L, 32'h0, L, 32'h0, L, 32'h0, 32'h0, L));
        #1 check_outputs("post_rst_440", 32'h440, L);
        @(negedge clk);
        #1 check_outputs("post_rst_444", 32'h444, L);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
